// File: rtl/pid_sat_controller_if.sv
// pid_sat_controller_if: sample request, gains and servo command bundle for the PID controller
interface pid_sat_controller_if #(
    parameter int WIDTH = 12
) ();
    logic                    start_i;
    logic                    int_clr_i;
    logic signed [WIDTH-1:0] ref_i;
    logic signed [WIDTH-1:0] y_i;
    logic signed [WIDTH-1:0] kp_i;
    logic signed [WIDTH-1:0] ki_i;
    logic signed [WIDTH-1:0] kd_i;
    logic signed [WIDTH-1:0] u_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    sat_o;
    modport master (
        output start_i, int_clr_i, ref_i, y_i, kp_i, ki_i, kd_i,
        input  u_o, busy_o, done_o, sat_o
    );
    modport slave (
        input  start_i, int_clr_i, ref_i, y_i, kp_i, ki_i, kd_i,
        output u_o, busy_o, done_o, sat_o
    );
endinterface

// File: rtl/pid_sat_controller.sv
// pid_sat_controller: saturating PID with shared multiplier, anti-windup and fixed 7-state schedule
module pid_sat_controller #(
    parameter int WIDTH   = 12,
    parameter int FRAC    = 8,
    parameter int OUT_MAX = 2047,
    parameter int OUT_MIN = -2048
) (
    input logic clk_i,
    input logic reset,
    pid_sat_controller_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam logic signed [W2-1:0] W_MAX = W2'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [W2-1:0] W_MIN = W2'(-(2 ** (WIDTH - 1)));
    localparam logic signed [W2-1:0] L_MAX = W2'(OUT_MAX);
    localparam logic signed [W2-1:0] L_MIN = W2'(OUT_MIN);

    typedef enum logic [2:0] {IDLE, LOAD, MUL_P, MUL_I, MUL_D, SUM, DONE} state_t;

    function automatic logic signed [W2-1:0] ext(input logic signed [WIDTH-1:0] x);
        return W2'(x);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [W2-1:0] v);
        return v > W_MAX ? WIDTH'(W_MAX) : v < W_MIN ? WIDTH'(W_MIN) : WIDTH'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] clamp_l(input logic signed [W2-1:0] v);
        return v > L_MAX ? WIDTH'(L_MAX) : v < L_MIN ? WIDTH'(L_MIN) : WIDTH'(v);
    endfunction

    state_t state, state_nx;
    logic signed [WIDTH-1:0] ref_r, y_r, kp_r, ki_r, kd_r;
    logic signed [WIDTH-1:0] e, de, e_prev, integ, p, d, di, i_new;
    logic signed [WIDTH-1:0] e_c, ma, mb, term;
    logic signed [W2-1:0] prod, s;
    logic hold;

    always_comb begin
        state_nx = state == IDLE ? (bus.start_i ? LOAD : IDLE) :
                   state == DONE ? IDLE : state_t'(state + 3'd1);
    end

    // one multiplier, operands steered by the current MUL_* state
    always_comb begin
        ma   = state == MUL_P ? kp_r : state == MUL_I ? ki_r : kd_r;
        mb   = state == MUL_D ? de : e;
        prod = ext(ma) * ext(mb);
        term = sat_w(prod >>> FRAC);
        e_c  = sat_w(ext(ref_r) - ext(y_r));
        s    = ext(p) + ext(i_new) + ext(d);
    end

    assign bus.busy_o = state != IDLE;
    assign bus.done_o = state == DONE;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state     <= IDLE;
            ref_r     <= '0;
            y_r       <= '0;
            kp_r      <= '0;
            ki_r      <= '0;
            kd_r      <= '0;
            e         <= '0;
            de        <= '0;
            e_prev    <= '0;
            integ     <= '0;
            p         <= '0;
            d         <= '0;
            di        <= '0;
            i_new     <= '0;
            hold      <= 1'b0;
            bus.u_o   <= '0;
            bus.sat_o <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.int_clr_i) begin
                integ  <= '0;
                e_prev <= '0;
            end
            if (state == IDLE && bus.start_i) begin
                ref_r <= bus.ref_i;
                y_r   <= bus.y_i;
                kp_r  <= bus.kp_i;
                ki_r  <= bus.ki_i;
                kd_r  <= bus.kd_i;
            end
            if (state == LOAD) begin
                e  <= e_c;
                de <= sat_w(ext(e_c) - ext(e_prev));
            end
            if (state == MUL_P) p <= term;
            if (state == MUL_I) begin
                di    <= term;
                i_new <= clamp_l(ext(integ) + ext(term));
            end
            if (state == MUL_D) d <= term;
            if (state == SUM) begin
                bus.u_o   <= clamp_l(s);
                bus.sat_o <= s > L_MAX || s < L_MIN;
                hold      <= (s > L_MAX && !di[WIDTH-1] && |di) || (s < L_MIN && di[WIDTH-1]);
            end
            // integrator freezes while pushing further into a clamped output
            if (state == DONE) begin
                e_prev <= e;
                if (!hold) integ <= i_new;
            end
        end
    end
endmodule
